// File: rtl/mul_sequencer.sv
// Sequential shift-add unsigned multiplier controller that drives an external ALU one step per cycle.
// Optional build macro MUL_ZERO_BYPASS_EN short-circuits a zero operand straight to DONE.
module mul_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [WIDTH-1:0]     alu_result,
    input  logic                 alu_cout,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    output logic [2:0]           alu_op,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done
);

    localparam int CountWidth = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CountWidth-1:0] LastCount = CountWidth'(WIDTH - 1);
    localparam logic [2:0] OpMulStep = 3'b010;
    localparam logic [2:0] OpNone    = 3'b000;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } stateT;

    stateT                  state;
    logic [WIDTH-1:0]       mcand;
    logic [CountWidth-1:0]  count;

    logic [WIDTH-1:0]       upperHalf;
    logic [WIDTH-1:0]       stepUpper;
    logic                   stepCarry;
    logic [2*WIDTH-1:0]     stepProduct;

    assign upperHalf = product[2*WIDTH-1:WIDTH];
    assign alu_a     = upperHalf;
    assign alu_b     = mcand;

    // One multiply step: optionally add the multiplicand into the upper half,
    // then shift the carry-extended product right so no carry is ever lost.
    always_comb begin
        stepUpper = upperHalf;
        stepCarry = 1'b0;
        if (product[0]) begin
            stepUpper = alu_result;
            stepCarry = alu_cout;
        end
        stepProduct = {stepCarry, stepUpper, product[WIDTH-1:1]};
    end

    // Control FSM; every output apart from the ALU operands is registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            product <= '0;
            mcand   <= '0;
            count   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            alu_op  <= OpNone;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
`ifdef MUL_ZERO_BYPASS_EN
                        if ((multiplicand == '0) || (multiplier == '0)) begin
                            product <= '0;
                            mcand   <= multiplicand;
                            count   <= '0;
                            busy    <= 1'b1;
                            done    <= 1'b1;
                            alu_op  <= OpNone;
                            state   <= DONE;
                        end else begin
                            product <= {{WIDTH{1'b0}}, multiplier};
                            mcand   <= multiplicand;
                            count   <= '0;
                            busy    <= 1'b1;
                            alu_op  <= OpMulStep;
                            state   <= CALC;
                        end
`else
                        product <= {{WIDTH{1'b0}}, multiplier};
                        mcand   <= multiplicand;
                        count   <= '0;
                        busy    <= 1'b1;
                        alu_op  <= OpMulStep;
                        state   <= CALC;
`endif
                    end
                end
                CALC: begin
                    product <= stepProduct;
                    count   <= count + 1'b1;
                    if (count == LastCount) begin
                        done   <= 1'b1;
                        alu_op <= OpNone;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                    alu_op <= OpNone;
                end
            endcase
        end
    end

endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Sequential 32x32 unsigned shift-add multiplier controller. It owns the product and multiplicand registers and drives the ALU's multiply-step operands and select. It consumes the ALU sum and carry each iteration. It sits beside the 32-bit ALU in the datapath and returns a 64-bit product with a one-cycle done pulse.

## Interface
Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH; iteration count equals WIDTH

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- start  in  1  request; sampled only in IDLE
- multiplicand  in  WIDTH  sampled on accepted start
- multiplier  in  WIDTH  sampled on accepted start
- alu_result  in  WIDTH  ALU sum of alu_a + alu_b
- alu_cout  in  1  ALU MSB carry-out
- alu_a  out  WIDTH  upper product half to ALU p-input
- alu_b  out  WIDTH  multiplicand to ALU mul-input
- alu_op  out  3  3'b010 in CALC, else 3'b000
- product  out  2*WIDTH  product register
- busy  out  1  high in CALC and DONE
- done  out  1  one-cycle pulse, product valid

## Operation
- States: IDLE, CALC, DONE. Reset value of every register and output: IDLE, product=0, mcand=0, count=0, busy=0, done=0, alu_op=3'b000, alu_a=0, alu_b=0.
- IDLE + start=1: load product <= {WIDTH'b0, multiplier}, mcand <= multiplicand, count <= 0, go to CALC.
- IDLE + start=0: hold all state.
- CALC, each cycle:
  - If product[0]=1: upper = alu_result, c = alu_cout.
  - Else: upper = product[2W-1:W], c = 0.
  - product <= {c, upper, product[W-1:1]} (65-bit value shifted right by 1, truncated to 2W); count <= count+1.
  - When count = WIDTH-1, go to DONE.
- DONE: done=1 for one cycle, then go to IDLE. Product holds until the next accepted start.
- alu_a = product[2W-1:W]; alu_b = mcand. Both are combinational from registers.
- start while busy=1 is ignored and does not queue. Operand input changes after the accepting edge have no effect.
- reset mid-CALC or in DONE: next state IDLE, all registers cleared, no done pulse.
- Arithmetic is unsigned, with no overflow. The carry enters bit 2W-1 before the shift, so the full 2W-bit result is exact.

## Timing
- The start edge is cycle 0. CALC occupies cycles 1..WIDTH (32 cycles). done=1 in cycle WIDTH+1 (33).
- The earliest next start is accepted at the edge ending cycle WIDTH+2 (first IDLE cycle). Throughput is one multiply per 34 cycles.
- The ALU path is purely combinational within one CALC cycle. alu_result must settle in the same cycle alu_a/alu_b change.
- busy rises the cycle after the accepted start and falls the cycle after done.

## Configuration
- MUL_ZERO_BYPASS_EN defined: IDLE + start with multiplicand=0 or multiplier=0 loads product <= 0 and goes directly to DONE. done=1 in cycle 1. CALC is skipped; alu_op stays 3'b000.
- Undefined: zero operands take the full 33-cycle path and produce product=0. The bypass logic is absent.

## Test plan
- Apply start with 3 x 5 -> product=64'd15; done=1 exactly at cycle 33; busy high cycles 1-33; alu_op=3'b010 only in cycles 1-32.
- Apply start with 0xFFFFFFFF x 0xFFFFFFFF -> product=0xFFFFFFFE00000001. Carry path exercised on every iteration.
- Apply start with 0x80000000 x 0x00000002 -> product=0x0000000100000000. Also run 0x12345678 x 0x9ABCDEF0 -> 0x0B00EA4E242D2080.
- Pulse start again at cycle 10 with new operands during a 7 x 9 run -> ignored; product=63 at cycle 33; next start accepted at cycle 34.
- Assert reset at cycle 15 of a run -> next cycle IDLE, product=0, busy=0, no done pulse. A subsequent 6 x 7 gives 42 at cycle 33.
- Apply start with 0 x 0x1234: with MUL_ZERO_BYPASS_EN -> done at cycle 1, product=0. Without it -> done at cycle 33, product=0.
